// File: rtl/multi_timer.sv
// multi_timer: CHANNELS independent one-shot/periodic/free-run timers with CTRL,
// PRESET, COUNT and W1C STATUS registers; masked per-channel requests ORed onto intreq.
module multi_timer #(
  parameter  int WIDTH    = 32,
  parameter  int CHANNELS = 2,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int ADDR_W   = CH_W + 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [ADDR_W-1:0]   devaddr,
  input  logic [WIDTH-1:0]    in,
  output logic [WIDTH-1:0]    out,
  output logic                intreq,
  output logic [CHANNELS-1:0] intreq_vec
);

  typedef enum logic [1:0] {
    REG_CTRL   = 2'b00,
    REG_PRESET = 2'b01,
    REG_COUNT  = 2'b10,
    REG_STATUS = 2'b11
  } reg_e;

  typedef enum logic [1:0] {
    MODE_ONESHOT  = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_FREERUN  = 2'b10,
    MODE_RSVD     = 2'b11
  } mode_e;

  logic [3:0]          ctrl_q   [CHANNELS];
  logic [3:0]          ctrl_d   [CHANNELS];
  logic [WIDTH-1:0]    preset_q [CHANNELS];
  logic [WIDTH-1:0]    preset_d [CHANNELS];
  logic [WIDTH-1:0]    count_q  [CHANNELS];
  logic [WIDTH-1:0]    count_d  [CHANNELS];
  logic [CHANNELS-1:0] pend_q;
  logic [CHANNELS-1:0] pend_d;
  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] fire;

  logic [CH_W-1:0] ch_sel;
  reg_e            reg_sel;

  assign ch_sel  = devaddr[ADDR_W-1:2];
  assign reg_sel = reg_e'(devaddr[1:0]);

  // Out-of-range channel indices match no channel, so they read 0 and drop writes.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = we && (ch_sel == CH_W'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      ctrl_d[i]   = ctrl_q[i];
      preset_d[i] = preset_q[i];
      count_d[i]  = count_q[i];
      fire[i]     = 1'b0;
      if (ctrl_q[i][0]) begin
        case (mode_e'(ctrl_q[i][2:1]))
          MODE_ONESHOT: begin
            if (count_q[i] != '0) count_d[i] = count_q[i] - WIDTH'(1);
            else begin
              ctrl_d[i][0] = 1'b0;
              fire[i]      = 1'b1;
            end
          end
          MODE_PERIODIC: begin
            if (count_q[i] != '0) count_d[i] = count_q[i] - WIDTH'(1);
            else begin
              count_d[i] = preset_q[i];
              fire[i]    = 1'b1;
            end
          end
          MODE_FREERUN: begin
            count_d[i] = count_q[i] + WIDTH'(1);
            fire[i]    = &count_q[i];
          end
          default: ;
        endcase
      end
      // Bus writes land after the counting logic so they win any collision.
      if (wr_hit[i]) begin
        case (reg_sel)
          REG_CTRL:   ctrl_d[i] = in[3:0];
          REG_PRESET: begin
            preset_d[i] = in;
            count_d[i]  = in;
          end
          default: ;
        endcase
      end
      pend_d[i] = fire[i] | (pend_q[i] & ~(wr_hit[i] && (reg_sel == REG_STATUS) && in[0]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        ctrl_q[i]   <= '0;
        preset_q[i] <= '0;
        count_q[i]  <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        ctrl_q[i]   <= ctrl_d[i];
        preset_q[i] <= preset_d[i];
        count_q[i]  <= count_d[i];
      end
      pend_q <= pend_d;
    end
  end

  always_comb begin
    out = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel == CH_W'(i)) begin
        case (reg_sel)
          REG_CTRL:   out = WIDTH'(ctrl_q[i]);
          REG_PRESET: out = preset_q[i];
          REG_COUNT:  out = count_q[i];
          REG_STATUS: out = WIDTH'(pend_q[i]);
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      intreq_vec[i] = pend_q[i] & ctrl_q[i][3];
    end
  end

  assign intreq = |intreq_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer (WIDTH=8, CHANNELS=3): directed scenarios plus a random
// register-traffic run checked against a behavioural register model.
module tb_multi_timer;
  localparam int W   = 8;
  localparam int NCH = 3;
  localparam int AW  = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           we;
  logic [AW-1:0]  devaddr;
  logic [W-1:0]   din;
  logic [W-1:0]   dout;
  logic           intreq;
  logic [NCH-1:0] intreq_vec;

  int n_checks = 0;
  int n_fail   = 0;

  int m_ctrl   [NCH];
  int m_preset [NCH];
  int m_count  [NCH];
  bit m_pend   [NCH];

  multi_timer #(.WIDTH(W), .CHANNELS(NCH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .devaddr    (devaddr),
    .in         (din),
    .out        (dout),
    .intreq     (intreq),
    .intreq_vec (intreq_vec)
  );

  always #50 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_ctrl[i] = 0; m_preset[i] = 0; m_count[i] = 0; m_pend[i] = 0;
    end
  endfunction

  // One clock edge of the register-level behaviour.
  function automatic void model_edge(bit w, int a, int d);
    int ch = a / 4;
    int r  = a % 4;
    for (int i = 0; i < NCH; i++) begin
      int c     = m_ctrl[i];
      int cnt   = m_count[i];
      int nc    = cnt;
      int nctrl = c;
      bit fired = 0;
      bit hit   = w && (ch == i);
      if (c % 2 == 1) begin
        case ((c / 2) % 4)
          0: if (cnt > 0) nc = cnt - 1; else begin nctrl = c - 1; fired = 1; end
          1: if (cnt > 0) nc = cnt - 1; else begin nc = m_preset[i]; fired = 1; end
          2: begin nc = (cnt + 1) % (1 << W); fired = (cnt == (1 << W) - 1); end
          default: ;
        endcase
      end
      if (hit && r == 0) nctrl = d % 16;
      if (hit && r == 1) begin m_preset[i] = d; nc = d; end
      if (fired) m_pend[i] = 1;
      else if (hit && r == 3 && (d % 2 == 1)) m_pend[i] = 0;
      m_ctrl[i]  = nctrl;
      m_count[i] = nc;
    end
  endfunction

  function automatic int model_read(int a);
    int ch = a / 4;
    if (ch >= NCH) return 0;
    case (a % 4)
      0: return m_ctrl[ch];
      1: return m_preset[ch];
      2: return m_count[ch];
      default: return int'(m_pend[ch]);
    endcase
  endfunction

  function automatic int model_vec();
    int v = 0;
    for (int i = 0; i < NCH; i++)
      if (m_pend[i] && ((m_ctrl[i] / 8) % 2 == 1)) v += (1 << i);
    return v;
  endfunction

  task automatic cycle(input bit w, input int a, input int d);
    we = w; devaddr = AW'(a); din = W'(d);
    @(posedge clk);
    model_edge(w, a, d);
    #1;
    we = 1'b0;
  endtask

  task automatic peek(input int a, output int v);
    devaddr = AW'(a);
    #1;
    v = int'(dout);
  endtask

  task automatic test_reset();
    int v;
    peek(0, v);
    n_checks++; if (v !== 0) begin n_fail++; $display("FAIL por_out got=%0h exp=0", v); end
    n_checks++; if (intreq !== 1'b0) begin n_fail++; $display("FAIL por_intreq got=%b exp=0", intreq); end
    n_checks++; if (intreq_vec !== 3'b000) begin n_fail++; $display("FAIL por_vec got=%b exp=000", intreq_vec); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(1, 1, 0); cycle(1, 0, 9); cycle(0, 0, 0);
    n_checks++; if (intreq !== 1'b1) begin n_fail++; $display("FAIL pre_rst_intreq got=%b exp=1", intreq); end
    cycle(1, 5, 5); cycle(1, 4, 9);
    peek(6, v);
    n_checks++; if (v !== 5) begin n_fail++; $display("FAIL pre_rst_count got=%0d exp=5", v); end
    rst_n = 1'b0;
    model_reset();
    for (int a = 0; a < 16; a++) begin
      peek(a, v);
      n_checks++; if (v !== 0) begin n_fail++; $display("FAIL rst_read addr=%0d got=%0h exp=0", a, v); end
    end
    n_checks++; if (intreq !== 1'b0) begin n_fail++; $display("FAIL rst_intreq got=%b exp=0", intreq); end
    n_checks++; if (intreq_vec !== 3'b000) begin n_fail++; $display("FAIL rst_vec got=%b exp=000", intreq_vec); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    peek(6, v);
    n_checks++; if (v !== 0) begin n_fail++; $display("FAIL post_rst_count got=%0d exp=0", v); end
    n_checks++; if (intreq !== 1'b0) begin n_fail++; $display("FAIL post_rst_intreq got=%b exp=0", intreq); end
  endtask

  task automatic test_oneshot();
    int v;
    cycle(1, 1, 3); cycle(1, 0, 9);
    peek(2, v);
    n_checks++; if (v !== 3) begin n_fail++; $display("FAIL os_start got=%0d exp=3", v); end
    for (int k = 2; k >= 0; k--) begin
      cycle(0, 0, 0);
      peek(2, v);
      n_checks++; if (v !== k) begin n_fail++; $display("FAIL os_count got=%0d exp=%0d", v, k); end
      n_checks++; if (intreq !== 1'b0) begin n_fail++; $display("FAIL os_early_irq got=%b exp=0", intreq); end
    end
    cycle(0, 0, 0);
    peek(0, v);
    n_checks++; if (v !== 8) begin n_fail++; $display("FAIL os_ctrl got=%0h exp=8", v); end
    peek(3, v);
    n_checks++; if (v !== 1) begin n_fail++; $display("FAIL os_pend got=%0d exp=1", v); end
    n_checks++; if (intreq !== 1'b1) begin n_fail++; $display("FAIL os_irq got=%b exp=1", intreq); end
    n_checks++; if (intreq_vec !== 3'b001) begin n_fail++; $display("FAIL os_vec got=%b exp=001", intreq_vec); end
    cycle(0, 0, 0); cycle(0, 0, 0);
    peek(2, v);
    n_checks++; if (v !== 0) begin n_fail++; $display("FAIL os_hold got=%0d exp=0", v); end
    n_checks++; if (intreq !== 1'b1) begin n_fail++; $display("FAIL os_irq_sticky got=%b exp=1", intreq); end
    cycle(1, 3, 1);
    peek(3, v);
    n_checks++; if (v !== 0) begin n_fail++; $display("FAIL os_w1c got=%0d exp=0", v); end
    n_checks++; if (intreq !== 1'b0) begin n_fail++; $display("FAIL os_irq_clr got=%b exp=0", intreq); end
    n_checks++; if (intreq_vec !== 3'b000) begin n_fail++; $display("FAIL os_vec_clr got=%b exp=000", intreq_vec); end
  endtask

  task automatic test_periodic();
    int v;
    cycle(1, 5, 2); cycle(1, 4, 11);
    for (int e = 1; e <= 12; e++) begin
      if (e % 3 == 1 || e == 12) cycle(1, 7, 1);
      else cycle(0, 0, 0);
      peek(6, v);
      n_checks++; if (v !== 2 - (e % 3)) begin n_fail++; $display("FAIL per_count edge=%0d got=%0d exp=%0d", e, v, 2 - (e % 3)); end
      peek(7, v);
      n_checks++; if (v !== ((e % 3 == 0) ? 1 : 0)) begin n_fail++; $display("FAIL per_pend edge=%0d got=%0d exp=%0d", e, v, (e % 3 == 0) ? 1 : 0); end
    end
    n_checks++; if (intreq_vec !== 3'b010) begin n_fail++; $display("FAIL per_vec got=%b exp=010", intreq_vec); end
    peek(2, v);
    n_checks++; if (v !== 0) begin n_fail++; $display("FAIL per_ch0_idle got=%0d exp=0", v); end
    cycle(1, 4, 0); cycle(1, 7, 1);
    n_checks++; if (intreq !== 1'b0) begin n_fail++; $display("FAIL per_cleanup got=%b exp=0", intreq); end
  endtask

  task automatic test_freerun();
    int v;
    cycle(1, 9, 'hFE); cycle(1, 8, 5);
    peek(10, v);
    n_checks++; if (v !== 'hFE) begin n_fail++; $display("FAIL fr_start got=%0h exp=fe", v); end
    cycle(0, 0, 0);
    peek(10, v);
    n_checks++; if (v !== 'hFF) begin n_fail++; $display("FAIL fr_ff got=%0h exp=ff", v); end
    peek(11, v);
    n_checks++; if (v !== 0) begin n_fail++; $display("FAIL fr_pend_early got=%0d exp=0", v); end
    cycle(0, 0, 0);
    peek(10, v);
    n_checks++; if (v !== 0) begin n_fail++; $display("FAIL fr_wrap got=%0h exp=0", v); end
    peek(11, v);
    n_checks++; if (v !== 1) begin n_fail++; $display("FAIL fr_pend got=%0d exp=1", v); end
    n_checks++; if (intreq !== 1'b0) begin n_fail++; $display("FAIL fr_masked got=%b exp=0", intreq); end
    cycle(1, 8, 'hD);
    n_checks++; if (intreq !== 1'b1) begin n_fail++; $display("FAIL fr_unmask got=%b exp=1", intreq); end
    n_checks++; if (intreq_vec !== 3'b100) begin n_fail++; $display("FAIL fr_vec got=%b exp=100", intreq_vec); end
    cycle(1, 8, 0); cycle(1, 11, 1);
  endtask

  task automatic test_collisions();
    int v;
    cycle(1, 1, 1); cycle(1, 0, 9); cycle(0, 0, 0);
    cycle(1, 1, 7);
    peek(2, v);
    n_checks++; if (v !== 7) begin n_fail++; $display("FAIL col_preset got=%0d exp=7", v); end
    peek(3, v);
    n_checks++; if (v !== 1) begin n_fail++; $display("FAIL col_preset_pend got=%0d exp=1", v); end
    peek(0, v);
    n_checks++; if (v !== 8) begin n_fail++; $display("FAIL col_preset_ctrl got=%0h exp=8", v); end
    cycle(1, 3, 1);
    cycle(1, 1, 0); cycle(1, 0, 9); cycle(1, 0, 9);
    peek(0, v);
    n_checks++; if (v !== 9) begin n_fail++; $display("FAIL col_ctrl_en got=%0h exp=9", v); end
    peek(3, v);
    n_checks++; if (v !== 1) begin n_fail++; $display("FAIL col_ctrl_pend got=%0d exp=1", v); end
    cycle(1, 0, 0); cycle(1, 3, 1);
    peek(3, v);
    n_checks++; if (v !== 0) begin n_fail++; $display("FAIL col_cleanup got=%0d exp=0", v); end
  endtask

  task automatic test_addr_decode();
    int v;
    cycle(1, 1, 'h21); cycle(1, 5, 'h33); cycle(1, 9, 'h44);
    for (int a = 12; a < 16; a++) cycle(1, a, 'hFF);
    for (int a = 12; a < 16; a++) begin
      peek(a, v);
      n_checks++; if (v !== 0) begin n_fail++; $display("FAIL dec_ch3 addr=%0d got=%0h exp=0", a, v); end
    end
    peek(2, v);
    n_checks++; if (v !== 'h21) begin n_fail++; $display("FAIL dec_ch0 got=%0h exp=21", v); end
    peek(6, v);
    n_checks++; if (v !== 'h33) begin n_fail++; $display("FAIL dec_ch1 got=%0h exp=33", v); end
    peek(10, v);
    n_checks++; if (v !== 'h44) begin n_fail++; $display("FAIL dec_ch2 got=%0h exp=44", v); end
    peek(8, v);
    n_checks++; if (v !== 0) begin n_fail++; $display("FAIL dec_ch2_ctrl got=%0h exp=0", v); end
    cycle(1, 6, 'h55);
    peek(6, v);
    n_checks++; if (v !== 'h33) begin n_fail++; $display("FAIL dec_count_ro got=%0h exp=33", v); end
  endtask

  task automatic test_random();
    int v;
    for (int n = 0; n < 300; n++) begin
      bit w = ($urandom_range(0, 2) != 0);
      int a = $urandom_range(0, 15);
      int d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
      cycle(w, a, d);
      for (int r = 0; r < 16; r++) begin
        peek(r, v);
        n_checks++;
        if (v !== model_read(r)) begin
          n_fail++; $display("FAIL rnd_read iter=%0d addr=%0d got=%0h exp=%0h", n, r, v, model_read(r));
        end
      end
      n_checks++;
      if (int'(intreq_vec) !== model_vec()) begin
        n_fail++; $display("FAIL rnd_vec iter=%0d got=%b exp=%0h", n, intreq_vec, model_vec());
      end
      n_checks++;
      if (intreq !== (model_vec() != 0)) begin
        n_fail++; $display("FAIL rnd_intreq iter=%0d got=%b exp=%0d", n, intreq, model_vec() != 0);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    we      = 1'b0;
    devaddr = '0;
    din     = '0;
    model_reset();
    test_reset();
    test_oneshot();
    test_periodic();
    test_freerun();
    test_collisions();
    test_addr_decode();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
